alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/sync_fifo.sv | 53 +++++
 rtl/alu_cmd_sequencer.sv | 111 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Opcodes, FSM states and the command bundle carried through the FIFO.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_INC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_DEC  = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_INV  = 4'd8,
    OP_AND  = 4'd9,
    OP_OR   = 4'd10,
    OP_NAND = 4'd11,
    OP_NOR  = 4'd12,
    OP_XOR  = 4'd13,
    OP_XNOR = 4'd14,
    OP_BUF  = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESULT
  } state_t;

  localparam logic [15:0] DIV_ZERO_RESULT = 16'hFFFF;
  localparam int CMD_W = 20;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  function automatic logic is_div0(cmd_t c);
    return (c.op == OP_DIV) && (c.b == 8'd0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth, simultaneous push/pop.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues each for one cycle to an external ALU,
// and holds the captured result until the consumer accepts it.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_com,
  output logic        alu_en,
  input  logic [15:0] alu_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [3:0]  res_op,
  output logic        res_err,
  output logic        busy
);

  state_t           state;
  state_t           nstate;
  cmd_t             in_cmd;
  cmd_t             head;
  cmd_t             cur;
  logic [CMD_W-1:0] head_bits;
  logic             pop;
  logic             full;
  logic             empty;

  assign in_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign head   = head_bits;

  sync_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (cmd_valid),
    .din  (in_cmd),
    .pop  (pop),
    .dout (head_bits),
    .full (full),
    .empty(empty)
  );

  assign cmd_ready = ~full;
  assign busy      = ~empty | (state != S_IDLE);
  assign alu_a     = cur.a;
  assign alu_b     = cur.b;
  assign alu_com   = cur.op;

  always_comb begin
    nstate    = state;
    pop       = 1'b0;
    alu_en    = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          nstate = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // a divide by zero never reaches the ALU bus
        alu_en = ~is_div0(cur);
        nstate = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (!empty) begin
            pop    = 1'b1;
            nstate = S_ISSUE;
          end else begin
            nstate = S_IDLE;
          end
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur      <= '0;
      res_data <= '0;
      res_op   <= '0;
      res_err  <= 1'b0;
    end else begin
      state <= nstate;
      if (pop) cur <= head;
      if (state == S_ISSUE) begin
        res_data <= is_div0(cur) ? DIV_ZERO_RESULT : alu_y;
        res_op   <= cur.op;
        res_err  <= is_div0(cur);
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU and
// an in-order result scoreboard.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_com;
  logic        alu_en;
  wire  [15:0] alu_y;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [3:0]  res_op;
  logic        res_err;
  logic        busy;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  op;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_xfer = 0;
  int   xfers = 0;
  int   n;
  int   x0;
  bit   tp_on = 0;
  bit   have_prev = 0;
  bit   acc = 0;
  bit   div0_en = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(logic [7:0] a, logic [7:0] b,
                                        logic [3:0] op);
    logic [15:0] x;
    logic [15:0] y;
    x = {8'd0, a};
    y = {8'd0, b};
    case (op)
      4'd0:    return x + y;
      4'd1:    return x + 16'd1;
      4'd2:    return x - y;
      4'd3:    return x - 16'd1;
      4'd4:    return x * y;
      4'd5:    return (b == 8'd0) ? 16'h0000 : x / y;
      4'd6:    return x << 1;
      4'd7:    return x >> 1;
      4'd8:    return {8'd0, ~a};
      4'd9:    return {8'd0, a & b};
      4'd10:   return {8'd0, a | b};
      4'd11:   return {8'd0, ~(a & b)};
      4'd12:   return {8'd0, ~(a | b)};
      4'd13:   return {8'd0, a ^ b};
      4'd14:   return {8'd0, ~(a ^ b)};
      default: return x;
    endcase
  endfunction

  function automatic exp_t expf(logic [7:0] a, logic [7:0] b,
                                logic [3:0] op);
    exp_t e;
    e.op = op;
    e.err = (op == 4'd5) && (b == 8'd0);
    e.data = e.err ? 16'hFFFF : alu_f(a, b, op);
    return e;
  endfunction

  assign alu_y = alu_en ? alu_f(alu_a, alu_b, alu_com) : 16'hzzzz;

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_op   (cmd_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_com  (alu_com),
    .alu_en   (alu_en),
    .alu_y    (alu_y),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_op   (res_op),
    .res_err  (res_err),
    .busy     (busy)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluate what the coming edge will transfer, then advance past it.
  task automatic tick();
    exp_t e;
    acc = 0;
    if (rst_n) begin
      if (res_valid && res_ready) begin
        xfers++;
        if (sb.size() == 0) begin
          chk("sb_extra_result", {res_data, res_op, res_err}, 32'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("result", {res_data, res_op, res_err}, {e.data, e.op, e.err});
        end
        if (tp_on) begin
          if (have_prev) chk("interval", cyc - last_xfer, 2);
          have_prev = 1;
          last_xfer = cyc;
        end
      end
      if (cmd_valid && cmd_ready) begin
        sb.push_back(expf(cmd_a, cmd_b, cmd_op));
        acc = 1;
      end
      if (alu_en && alu_com == 4'd5 && alu_b == 8'd0) div0_en = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(logic [7:0] a, logic [7:0] b, logic [3:0] op);
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc) break;
    end
    chk("accept", acc, 1);
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic chk_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_alu_ab", {alu_a, alu_b, alu_com}, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", {res_data, res_op, res_err}, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single ADD: latency of two edges
    res_ready = 1'b1;
    send(8'h12, 8'h34, 4'd0);
    cmd_valid = 1'b0;
    chk("lat_k0_valid", res_valid, 0);
    chk("lat_k0_busy", busy, 1);
    tick();
    chk("issue_en", alu_en, 1);
    chk("issue_ops", {alu_a, alu_b, alu_com}, {8'h12, 8'h34, 4'd0});
    chk("lat_k1_valid", res_valid, 0);
    tick();
    chk("lat_k2_valid", res_valid, 1);
    chk("add_res", {res_data, res_op, res_err}, {16'h0046, 4'd0, 1'b0});
    chk("result_en_low", alu_en, 0);
    drain();

    // MUL extreme and divide by zero
    send(8'hFF, 8'hFF, 4'd4);
    send(8'd200, 8'd0, 4'd5);
    drain();
    chk("div0_no_en", div0_en, 0);

    // stalled consumer fills the FIFO
    res_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cmd_a = 8'(n * 3 + 1);
      cmd_b = 8'(n + 5);
      cmd_op = 4'(n + 4);
      cmd_valid = 1'b1;
      tick();
      if (acc) n++;
    end
    chk("full_count", n, DEPTH + 1);
    chk("full_ready", cmd_ready, 0);
    chk("stall_valid", res_valid, 1);
    chk("stall_head", res_data, sb[0].data);
    res_ready = 1'b1;
    send(8'(n * 3 + 1), 8'(n + 5), 4'(n + 4));
    drain();

    // streaming eight commands
    x0 = xfers;
    tp_on = 1;
    have_prev = 0;
    for (int i = 0; i < 8; i++)
      send(8'($urandom_range(255)), 8'($urandom_range(1, 255)), 4'(i * 3));
    drain();
    tp_on = 0;
    chk("stream_count", xfers - x0, 8);

    // reset while issuing with three queued
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(i + 1), 8'd2, 4'd0);
    cmd_valid = 1'b0;
    chk("pre_rst_full", cmd_ready, 0);
    res_ready = 1'b1;
    tick();
    chk("pre_rst_issue", alu_en, 1);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1 chk_reset();
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("post_rst_valid", res_valid, 0);
    chk("post_rst_busy", busy, 0);
    send(8'hA5, 8'h0F, 4'd13);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
